sound_event_sequencer: RTL and testbench

Plays a short fixed melody for each game sound event: ball hit, pocket, foul or win. On a one-cycle trigger it steps through notes held in an internal melody ROM. Each note is held for a programmable time, with a silent gap between notes. Its outputs drive one `sound_enable`/`tone_key` source input of the tone-key mux, which feeds the tone generator.

---
 rtl/sound_pkg.sv | 31 +++
 rtl/sound_melody_rom.sv | 13 +
 rtl/sound_event_sequencer.sv | 115 +++++++++++
 tb/tb_sound_event_sequencer.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/sound_pkg.sv
// Shared types and melody table for the game sound event sequencer.
// Table entries are {last, key}; notes after the flagged last entry are never read.
package sound_pkg;

    typedef enum logic [1:0] {
        HIT    = 2'd0,
        POCKET = 2'd1,
        FOUL   = 2'd2,
        WIN    = 2'd3
    } melody_id_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        GAP  = 2'd2
    } seq_state_t;

    typedef struct packed {
        logic       last;
        logic [3:0] key;
    } rom_entry_t;

    // Indexed [melody][note]; the first listed value is note 0 of melody 0.
    localparam logic [0:3][0:7][4:0] MELODY_ROM = {
        5'h09, 5'h1C, 5'h00, 5'h00, 5'h00, 5'h00, 5'h00, 5'h00,
        5'h00, 5'h04, 5'h07, 5'h1B, 5'h00, 5'h00, 5'h00, 5'h00,
        5'h0B, 5'h07, 5'h12, 5'h00, 5'h00, 5'h00, 5'h00, 5'h00,
        5'h00, 5'h02, 5'h04, 5'h05, 5'h07, 5'h09, 5'h0B, 5'h1C
    };

endpackage

// File: rtl/sound_melody_rom.sv
// Combinational melody lookup: (melody, note index) -> {last, key}.
// Zero latency, no flow control.
module sound_melody_rom
    import sound_pkg::*;
(
    input  melody_id_t sel,
    input  logic [2:0] idx,
    output rom_entry_t entry
);

    assign entry = rom_entry_t'(MELODY_ROM[sel][idx]);

endmodule

// File: rtl/sound_event_sequencer.sv
// Plays a fixed note/gap melody per game event; all outputs registered, one cycle after trigger.
// No backpressure: a new trigger always restarts the sequence immediately.
module sound_event_sequencer
    import sound_pkg::*;
#(
    parameter int TICKS_PER_MS = 50000,
    parameter int NOTE_MS      = 120,
    parameter int GAP_MS       = 20
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       trigger,
    input  logic [1:0] melody_sel,
    output logic       sound_enable,
    output logic [3:0] tone_key,
    output logic       busy
);

    localparam int PW = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICKS_PER_MS - 1);
    localparam logic [7:0]    NOTE_LAST = 8'(NOTE_MS - 1);
    localparam logic [7:0]    GAP_LAST  = 8'(GAP_MS - 1);

    seq_state_t    state, state_nxt;
    melody_id_t    sel, sel_nxt;
    logic [2:0]    idx, idx_nxt;
    logic [PW-1:0] presc, presc_nxt;
    logic [7:0]    ms_cnt, ms_nxt;
    logic          last_note, last_nxt;
    logic [3:0]    key_nxt;
    logic          ms_tick, period_done;
    melody_id_t    rom_sel;
    logic [2:0]    rom_idx;
    rom_entry_t    rom_q;

    // The single ROM port serves either the new melody's first note or the next note.
    assign rom_sel = trigger ? melody_id_t'(melody_sel) : sel;
    assign rom_idx = trigger ? 3'd0 : idx + 3'd1;

    sound_melody_rom u_rom (
        .sel   (rom_sel),
        .idx   (rom_idx),
        .entry (rom_q)
    );

    assign ms_tick     = (presc == PRESC_MAX);
    assign period_done = ms_tick && (ms_cnt == ((state == PLAY) ? NOTE_LAST : GAP_LAST));

    always_comb begin
        state_nxt = state;
        sel_nxt   = sel;
        idx_nxt   = idx;
        presc_nxt = presc;
        ms_nxt    = ms_cnt;
        last_nxt  = last_note;
        key_nxt   = tone_key;
        if (trigger) begin
            state_nxt = PLAY;
            sel_nxt   = melody_id_t'(melody_sel);
            idx_nxt   = 3'd0;
            presc_nxt = '0;
            ms_nxt    = 8'd0;
            key_nxt   = rom_q.key;
            last_nxt  = rom_q.last;
        end else if (state != IDLE) begin
            if (!ms_tick) begin
                presc_nxt = presc + 1'b1;
            end else if (!period_done) begin
                presc_nxt = '0;
                ms_nxt    = ms_cnt + 8'd1;
            end else begin
                presc_nxt = '0;
                ms_nxt    = 8'd0;
                if (state == PLAY) begin
                    if (last_note) begin
                        state_nxt = IDLE;
                        key_nxt   = 4'd0;
                    end else begin
                        state_nxt = GAP;
                    end
                end else begin
                    state_nxt = PLAY;
                    idx_nxt   = idx + 3'd1;
                    key_nxt   = rom_q.key;
                    last_nxt  = rom_q.last;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state        <= IDLE;
            sel          <= HIT;
            idx          <= 3'd0;
            presc        <= '0;
            ms_cnt       <= 8'd0;
            last_note    <= 1'b0;
            sound_enable <= 1'b0;
            tone_key     <= 4'd0;
            busy         <= 1'b0;
        end else begin
            state        <= state_nxt;
            sel          <= sel_nxt;
            idx          <= idx_nxt;
            presc        <= presc_nxt;
            ms_cnt       <= ms_nxt;
            last_note    <= last_nxt;
            sound_enable <= (state_nxt == PLAY);
            tone_key     <= key_nxt;
            busy         <= (state_nxt != IDLE);
        end
    end

endmodule

// File: tb/tb_sound_event_sequencer.sv
// Directed bench: 12-cycle notes, 8-cycle gaps; vector table plus reset and length sequences.
module tb_sound_event_sequencer;

    logic       clk = 1'b0;
    logic       resetN;
    logic       trigger;
    logic [1:0] melody_sel;
    logic       sound_enable;
    logic [3:0] tone_key;
    logic       busy;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int         cycles;
        logic       trig;
        logic [1:0] sel;
        logic       en;
        logic [3:0] key;
        logic       bsy;
    } vec_t;

    vec_t vecs[$];

    sound_event_sequencer #(
        .TICKS_PER_MS (4),
        .NOTE_MS      (3),
        .GAP_MS       (2)
    ) dut (
        .clk          (clk),
        .resetN       (resetN),
        .trigger      (trigger),
        .melody_sel   (melody_sel),
        .sound_enable (sound_enable),
        .tone_key     (tone_key),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic en, input logic [3:0] key, input logic bsy);
        check({tag, " sound_enable"}, 32'(sound_enable), 32'(en));
        check({tag, " tone_key"}, 32'(tone_key), 32'(key));
        check({tag, " busy"}, 32'(busy), 32'(bsy));
    endtask

    task automatic add(input int n, input logic t, input logic [1:0] s,
                       input logic e, input logic [3:0] k, input logic b);
        vec_t v;
        v.cycles = n; v.trig = t; v.sel = s; v.en = e; v.key = k; v.bsy = b;
        vecs.push_back(v);
    endtask

    initial begin
        int k3[8];
        int n;
        k3 = '{0, 2, 4, 5, 7, 9, 11, 12};

        // Melody 0: trigger, 12-cycle key 9, 8-cycle gap, 12-cycle key 12, then idle.
        add(12, 1, 0, 1, 9, 1);
        add(8,  0, 0, 0, 9, 1);
        add(12, 0, 0, 1, 12, 1);
        add(3,  0, 0, 0, 0, 0);
        // Melody 3: full scale.
        for (int i = 0; i < 8; i++) begin
            add(12, (i == 0), 3, 1, 4'(k3[i]), 1);
            if (i < 7) add(8, 0, 3, 0, 4'(k3[i]), 1);
        end
        add(2, 0, 3, 0, 0, 0);
        // Melody 1 interrupted in its second gap by melody 2.
        add(12, 1, 1, 1, 0, 1);
        add(8,  0, 1, 0, 0, 1);
        add(12, 0, 1, 1, 4, 1);
        add(3,  0, 1, 0, 4, 1);
        add(12, 1, 2, 1, 11, 1);
        add(8,  0, 2, 0, 11, 1);
        add(12, 0, 2, 1, 7, 1);
        add(8,  0, 2, 0, 7, 1);
        add(12, 0, 2, 1, 2, 1);
        // Retrigger on the final cycle of the last note: no idle cycle in between.
        add(12, 1, 2, 1, 11, 1);
        add(8,  0, 2, 0, 11, 1);
        add(12, 0, 2, 1, 7, 1);
        add(8,  0, 2, 0, 7, 1);
        add(12, 0, 2, 1, 2, 1);
        add(4,  0, 2, 0, 0, 0);

        resetN     = 1'b1;
        trigger    = 1'b0;
        melody_sel = 2'd0;
        #2 resetN = 1'b0;
        #2 check_out("reset", 1'b0, 4'd0, 1'b0);
        step();
        step();
        resetN = 1'b1;

        for (int c = 0; c < 1000; c++) begin
            step();
            check_out($sformatf("idle c%0d", c), 1'b0, 4'd0, 1'b0);
        end

        for (int v = 0; v < vecs.size(); v++) begin
            trigger    = vecs[v].trig;
            melody_sel = vecs[v].sel;
            for (int c = 0; c < vecs[v].cycles; c++) begin
                step();
                trigger = 1'b0;
                check_out($sformatf("vec%0d c%0d", v, c), vecs[v].en, vecs[v].key, vecs[v].bsy);
            end
        end

        // Busy length of the 8-note melody.
        trigger    = 1'b1;
        melody_sel = 2'd3;
        step();
        trigger = 1'b0;
        n = 0;
        while (busy && n < 300) begin
            n++;
            step();
        end
        check("m3 busy length", 32'(n), 32'd152);
        step();

        // Reset asserted during the second note of melody 1.
        trigger    = 1'b1;
        melody_sel = 2'd1;
        step();
        trigger = 1'b0;
        for (int c = 0; c < 25; c++) step();
        check_out("pre-reset note2", 1'b1, 4'd4, 1'b1);
        #2 resetN = 1'b0;
        #1 check_out("async reset", 1'b0, 4'd0, 1'b0);
        for (int c = 0; c < 3; c++) begin
            step();
            check_out($sformatf("in reset c%0d", c), 1'b0, 4'd0, 1'b0);
        end
        resetN = 1'b1;
        for (int c = 0; c < 5; c++) begin
            step();
            check_out($sformatf("post reset c%0d", c), 1'b0, 4'd0, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
